multicycle_datapath: RTL and testbench

Parametrised multi-cycle successor to the single-cycle uPOWER load/store/R/I datapath. Accepts one 32-bit instruction at a time over a valid/ready handshake, then runs it through a DECODE/EXEC/MEM/WB state machine against an internal register file and doubleword data memory. A one-cycle writeback/done report follows each instruction. Sits between instruction fetch and the rest of the core.

---
 rtl/multicycle_datapath.sv | 243 ++++++++++++++++++++++++
 tb/tb_multicycle_datapath.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_datapath.sv
// multicycle_datapath
//   Multi-cycle uPOWER load/store/R/I datapath. Accepts one 32-bit
//   instruction over a valid/ready handshake, then walks it through
//   DECODE -> EXEC -> (MEM) -> WB against an internal GPR file and a
//   doubleword data memory. A one-cycle done/writeback report is given in WB.
//
//   Optional feature macro: DP_ALIGN_CHECK_EN
//     defined   : ld/std with EA[2:0] != 0 abort in EXEC and report err.
//     undefined : EA[2:0] is ignored; the truncated doubleword index is used.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   instr_valid  instruction offered
//   instr_ready  high only in IDLE
//   instr        32-bit instruction, captured on accept
//   done         one-cycle pulse in WB
//   err          valid with done: illegal encoding or misaligned access
//   wb_valid     GPR written at the end of this cycle
//   wb_reg       destination RT
//   wb_data      value written
//   halted       high in HALT
module multicycle_datapath #(
  parameter int DATA_W    = 64,
  parameter int NREGS     = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic              done,
  output logic              err,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              halted
);

  localparam int AW = $clog2(MEM_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] C_ALU  = 3'd0;
  localparam logic [2:0] C_ADDI = 3'd1;
  localparam logic [2:0] C_LD   = 3'd2;
  localparam logic [2:0] C_STD  = 3'd3;
  localparam logic [2:0] C_ILL  = 3'd4;
  localparam logic [2:0] C_HALT = 3'd5;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUBF = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;

  logic [2:0]        r_state;
  logic [31:0]       r_instr;
  logic [2:0]        r_class;
  logic [2:0]        r_aluop;
  logic              r_err;
  logic [DATA_W-1:0] r_res;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_gpr [NREGS];
  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  logic [5:0]        w_op;
  logic [4:0]        w_rt;
  logic [4:0]        w_ra;
  logic [4:0]        w_rb;
  logic [9:0]        w_xo;
  logic [2:0]        w_class;
  logic [2:0]        w_aluop;
  logic [DATA_W-1:0] w_ra_val;
  logic [DATA_W-1:0] w_ra0_val;
  logic [DATA_W-1:0] w_rb_val;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_ea;
  logic [AW-1:0]     w_idx;
  logic              w_wb_valid;

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] v);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'(v);
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [2:0] op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] y;
    case (op)
      OP_SUBF: y = b - a;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = a + b;
    endcase
    return y;
  endfunction

  assign w_op = r_instr[31:26];
  assign w_rt = r_instr[25:21];
  assign w_ra = r_instr[20:16];
  assign w_rb = r_instr[15:11];
  assign w_xo = r_instr[10:1];

  // Decode class from the captured instruction; used at the DECODE edge.
  always_comb begin
    w_class = C_ILL;
    w_aluop = OP_ADD;
    if (r_instr == 32'hFFFF_FFFF) begin
      w_class = C_HALT;
    end else begin
      case (w_op)
        6'd14: w_class = C_ADDI;
        6'd58: if (r_instr[1:0] == 2'b00) w_class = C_LD;
        6'd62: if (r_instr[1:0] == 2'b00) w_class = C_STD;
        6'd31: begin
          case (w_xo)
            10'd266: begin w_class = C_ALU; w_aluop = OP_ADD;  end
            10'd40:  begin w_class = C_ALU; w_aluop = OP_SUBF; end
            10'd28:  begin w_class = C_ALU; w_aluop = OP_AND;  end
            10'd444: begin w_class = C_ALU; w_aluop = OP_OR;   end
            10'd316: begin w_class = C_ALU; w_aluop = OP_XOR;  end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // GPR reads; indices beyond the implemented file read as zero.
  always_comb begin
    w_ra_val = '0;
    w_rb_val = '0;
    w_rs_val = '0;
    if (int'(w_ra) < NREGS) w_ra_val = r_gpr[w_ra];
    if (int'(w_rb) < NREGS) w_rb_val = r_gpr[w_rb];
    if (int'(w_rt) < NREGS) w_rs_val = r_gpr[w_rt];
  end

  // (RA|0): register 0 as a base/addend means literal zero.
  assign w_ra0_val = (w_ra == 5'd0) ? '0 : w_ra_val;
  assign w_ea      = r_opa + sext16({r_instr[15:2], 2'b00});
  assign w_idx     = r_res[3 +: AW];

  assign w_wb_valid  = (r_state == S_WB) && !r_err &&
                       ((r_class == C_ALU) || (r_class == C_ADDI) || (r_class == C_LD));
  assign instr_ready = (r_state == S_IDLE);
  assign done        = (r_state == S_WB);
  assign err         = (r_state == S_WB) && r_err;
  assign wb_valid    = w_wb_valid;
  assign wb_reg      = w_rt;
  assign wb_data     = r_res;
  assign halted      = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_class <= C_ILL;
      r_aluop <= OP_ADD;
      r_err   <= 1'b0;
      r_res   <= '0;
      for (int i = 0; i < NREGS; i++) r_gpr[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= S_DECODE;
          end
        end
        // DECODE -> EXEC: class and error latched; illegal/halt go straight to WB
        S_DECODE: begin
          r_class <= w_class;
          r_aluop <= w_aluop;
          r_err   <= (w_class == C_ILL);
          r_state <= ((w_class == C_ILL) || (w_class == C_HALT)) ? S_WB : S_EXEC;
        end
        // EXEC -> MEM/WB: ALU result or effective address registered
        S_EXEC: begin
          case (r_class)
            C_ALU: begin
              r_res   <= alu(r_aluop, r_opa, r_opb);
              r_state <= S_WB;
            end
            C_ADDI: begin
              r_res   <= r_opa + sext16(r_instr[15:0]);
              r_state <= S_WB;
            end
            default: begin
              r_res <= w_ea;
`ifdef DP_ALIGN_CHECK_EN
              if (w_ea[2:0] != 3'b000) begin
                r_err   <= 1'b1;
                r_state <= S_WB;
              end else begin
                r_state <= S_MEM;
              end
`else
              r_state <= S_MEM;
`endif
            end
          endcase
        end
        // MEM -> WB: load data replaces the address in the result register
        S_MEM: begin
          if (r_class == C_LD) r_res <= r_mem[w_idx];
          r_state <= S_WB;
        end
        // WB -> IDLE/HALT: GPR update at the exiting edge
        S_WB: begin
          if (w_wb_valid && (int'(w_rt) < NREGS)) r_gpr[w_rt] <= r_res;
          r_state <= (r_class == C_HALT) ? S_HALT : S_IDLE;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand latches and data memory carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) begin
      r_opa <= (w_class == C_ALU) ? w_ra_val : w_ra0_val;
      r_opb <= w_rb_val;
      r_rs  <= w_rs_val;
    end
    if ((r_state == S_MEM) && (r_class == C_STD)) r_mem[w_idx] <= r_rs;
  end

endmodule

// File: tb/tb_multicycle_datapath.sv
module tb_multicycle_datapath;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        done;
  logic        err;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [63:0] wb_data;
  logic        halted;

  multicycle_datapath #(.DATA_W(64), .NREGS(32), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .done(done), .err(err), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data), .halted(halted)
  );

  typedef struct {
    logic        err;
    logic        wbv;
    logic [4:0]  rg;
    logic [63:0] data;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] dform(input int op, input int rt, input int ra, input logic [15:0] imm);
    logic [31:0] w;
    w = {op[5:0], rt[4:0], ra[4:0], imm};
    return w;
  endfunction

  function automatic logic [31:0] xform(input int rt, input int ra, input int rb, input int xo);
    logic [31:0] w;
    w = {6'd31, rt[4:0], ra[4:0], rb[4:0], xo[9:0], 1'b0};
    return w;
  endfunction

  // Monitor: pops one expectation per done pulse.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected none queued (t=%0t)", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("err", 64'(err), 64'(e.err));
        chk("wb_valid", 64'(wb_valid), 64'(e.wbv));
        if (e.wbv) begin
          chk("wb_reg", 64'(wb_reg), 64'(e.rg));
          chk("wb_data", wb_data, e.data);
        end
        chk("latency", 64'(cyc - e.acc), 64'(e.lat));
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input logic push, input logic e_err,
                       input logic e_wbv, input int e_rg, input logic [63:0] e_data,
                       input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (instr_ready !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL ready_wait: got instr_ready=%b expected 1 within 30 cycles", instr_ready);
      return;
    end
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk);
    @(negedge clk);
    if (push) begin
      e.err = e_err; e.wbv = e_wbv; e.rg = e_rg[4:0]; e.data = e_data;
      e.lat = lat;   e.acc = cyc;
      q.push_back(e);
    end
    chk("busy_ready", 64'(instr_ready), 64'd0);
    // Offered while busy and changed after accept: must be ignored.
    instr = 32'h0000_0000;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"},    64'(instr_ready), 64'd1);
    chk({tag, "_done"},     64'(done),        64'd0);
    chk({tag, "_err"},      64'(err),         64'd0);
    chk({tag, "_wb_valid"}, 64'(wb_valid),    64'd0);
    chk({tag, "_halted"},   64'(halted),      64'd0);
    chk({tag, "_wb_reg"},   64'(wb_reg),      64'd0);
    chk({tag, "_wb_data"},  wb_data,          64'd0);
  endtask

  localparam logic [63:0] M3 = 64'hFFFF_FFFF_FFFF_FFFD;
  localparam logic [63:0] M8 = 64'hFFFF_FFFF_FFFF_FFF8;

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr = 32'h0;
    #3;
    reset_checks("rst0");
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    issue(dform(14, 1, 0, 16'd5),    1, 0, 1, 1, 64'd5, 2);
    issue(dform(14, 2, 0, 16'hFFFD), 1, 0, 1, 2, M3,    2);
    issue(xform(3, 1, 2, 266),       1, 0, 1, 3, 64'd2, 2);
    issue(xform(4, 1, 2, 40),        1, 0, 1, 4, M8,    2);
    issue(xform(8, 1, 2, 28),        1, 0, 1, 8, 64'd5, 2);
    issue(xform(9, 1, 2, 444),       1, 0, 1, 9, M3,    2);
    issue(xform(10, 1, 2, 316),      1, 0, 1, 10, M8,   2);
    issue(dform(14, 16, 2, 16'd10),  1, 0, 1, 16, 64'd7, 2);
    // std r1,16(r0) then ld r5,16(r0)
    issue(dform(62, 1, 0, 16'h0010), 1, 0, 0, 0, 64'd0, 3);
    issue(dform(58, 5, 0, 16'h0010), 1, 0, 1, 5, 64'd5, 3);
    // Illegal opcode 0 with RT=1: r1 must keep 5
    issue(32'h0020_0000,             1, 1, 0, 0, 64'd0, 1);
    issue(xform(14, 1, 1, 444),      1, 0, 1, 14, 64'd5, 2);
    // MEM[0] = -3, then ld r6,0(r1) with EA=5 (misaligned)
    issue(dform(62, 2, 0, 16'h0000), 1, 0, 0, 0, 64'd0, 3);
`ifdef DP_ALIGN_CHECK_EN
    issue(dform(58, 6, 1, 16'h0000), 1, 1, 0, 0, 64'd0, 2);
    issue(xform(15, 6, 6, 444),      1, 0, 1, 15, 64'd0, 2);
`else
    issue(dform(58, 6, 1, 16'h0000), 1, 0, 1, 6, M3,    3);
    issue(xform(15, 6, 6, 444),      1, 0, 1, 15, M3,   2);
`endif

    // Abort addi r7,r0,9 during EXEC
    issue(dform(14, 7, 0, 16'd9),    0, 0, 0, 0, 64'd0, 0);
    #2 rst = 1'b0;
    #1;
    reset_checks("rst_exec");
    @(negedge clk);
    rst = 1'b1;
    issue(xform(12, 7, 7, 444),      1, 0, 1, 12, 64'd0, 2);
    issue(xform(18, 1, 1, 444),      1, 0, 1, 18, 64'd0, 2);

    // Halt
    issue(32'hFFFF_FFFF,             1, 0, 0, 0, 64'd0, 1);
    @(negedge clk);
    instr_valid = 1'b1;
    instr       = dform(14, 1, 0, 16'd1);
    for (int i = 0; i < 4; i++) begin
      chk("halted", 64'(halted), 64'd1);
      chk("halt_ready", 64'(instr_ready), 64'd0);
      @(negedge clk);
    end
    instr_valid = 1'b0;
    rst = 1'b0;
    #1;
    reset_checks("rst_halt");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_halt_ready", 64'(instr_ready), 64'd1);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
